prog_loader: RTL and testbench

- Boot-time writer for the instruction memory that the fetch path reads.
- Receives a byte stream over a valid/ready handshake and assembles 9-bit machine-code words.
- Writes each word to sequential instruction-memory addresses.
- Holds the CPU in reset until the image is fully loaded, then releases it.
- Sits between the external byte source and the write port of the instruction ROM; the PC and fetch path are untouched.

---
 rtl/prog_loader.sv | 156 +++++++++++++++
 tb/tb_prog_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: boot-time instruction-memory writer.
// Accepts a byte stream (LEN_LO, LEN_HI, then LO/HI byte pairs per word),
// assembles 9-bit words, writes them to sequential addresses and holds the
// CPU in reset until the whole image has been loaded.
// Optional checksum stage enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    output logic         cpu_hold,
    output logic         load_done,
    output logic         load_err,
    output logic [D-1:0] word_cnt
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_WORD_LO,
        S_WORD_HI,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t       state;
    logic [D-1:0] len;
    logic [7:0]   lo;
    logic         accept;
    logic [11:0]  len_full;
    logic         last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]   acc;
`endif

    // Ready is decoded from state only: every loading state takes a byte.
    always_comb begin
        rx_ready = 1'b0;
        case (state)
            S_LEN_LO, S_LEN_HI, S_WORD_LO, S_WORD_HI: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:                                   rx_ready = 1'b1;
`endif
            default:                                 rx_ready = 1'b0;
        endcase
    end

    // Handshake decode, full length as seen in LEN_HI, and last-word detect.
    always_comb begin
        accept    = rx_valid && rx_ready;
        len_full  = {rx_data[3:0], len[7:0]};
        last_word = ((word_cnt + D'(1)) == len);
    end

    // Loader FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_LEN_LO;
            len       <= '0;
            lo        <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            word_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (accept && state != S_CHK)
                acc <= acc ^ rx_data;
`endif
            if (accept) begin
                case (state)
                    S_LEN_LO: begin
                        len   <= D'(rx_data);
                        state <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        if (rx_data[7:4] != 4'd0) begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end else begin
                            len <= D'(len_full);
                            if (len_full == 12'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state     <= S_CHK;
`else
                                state     <= S_DONE;
                                load_done <= 1'b1;
                                cpu_hold  <= 1'b0;
`endif
                            end else begin
                                state <= S_WORD_LO;
                            end
                        end
                    end
                    S_WORD_LO: begin
                        lo    <= rx_data;
                        state <= S_WORD_HI;
                    end
                    S_WORD_HI: begin
                        if (rx_data[7:1] != 7'd0) begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end else begin
                            wr_en    <= 1'b1;
                            wr_addr  <= word_cnt;
                            wr_data  <= W'({rx_data[0], lo});
                            word_cnt <= word_cnt + D'(1);
                            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                                state     <= S_CHK;
`else
                                state     <= S_DONE;
                                load_done <= 1'b1;
                                cpu_hold  <= 1'b0;
`endif
                            end else begin
                                state <= S_WORD_LO;
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (rx_data == acc) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end
                    end
`endif
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Expected writes are queued when the
// HI byte is driven and compared when wr_en is observed. Honours
// LOADER_CHECKSUM_EN by appending the XOR of the sent bytes to each image.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [8:0]  wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [11:0] word_cnt;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned n_wr   = 0;
    logic [7:0]  tb_xor;
    logic [20:0] exp_q[$];   // {addr[11:0], data[8:0]}

    prog_loader #(.D(12), .W(9)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every observed pulse must match the head of the queue.
    always @(negedge clk) begin
        if (wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {20'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {20'd0, wr_addr}, {20'd0, e[20:9]});
                check("wr_data", {23'd0, wr_data}, {23'd0, e[8:0]});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            tb_xor = tb_xor ^ b;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
        reset  = 1'b0;
        tb_xor = 8'h00;
    endtask

    // Send one word as LO/HI; queue the write when HI is legal.
    task automatic send_word(input logic [7:0] l, input logic [7:0] h, input logic [11:0] addr);
        if (h[7:1] == 7'd0) exp_q.push_back({addr, h[0], l});
        send(l);
        send(h);
    endtask

    task automatic finish_image();
`ifdef LOADER_CHECKSUM_EN
        send(tb_xor);
`endif
    endtask

    task automatic drain_check(input string tag);
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int unsigned w0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tb_xor   = 8'h00;
        do_reset();

        // Reset state
        check("rst_wr_en",  wr_en, 0);
        check("rst_addr",   wr_addr, 0);
        check("rst_data",   wr_data, 0);
        check("rst_hold",   cpu_hold, 1);
        check("rst_done",   load_done, 0);
        check("rst_err",    load_err, 0);
        check("rst_cnt",    word_cnt, 0);
        check("rst_ready",  rx_ready, 1);

        // Normal load, back-to-back bytes
        w0 = n_wr;
        send(8'h03); send(8'h00);
        send_word(8'hA5, 8'h01, 12'd0);
        send_word(8'h03, 8'h00, 12'd1);
        send_word(8'h00, 8'h01, 12'd2);
        finish_image();
        check("norm_done",  load_done, 1);
        check("norm_hold",  cpu_hold, 0);
        check("norm_cnt",   word_cnt, 3);
        check("norm_ready", rx_ready, 0);
        drain_check("norm_pending");
        check("norm_nwr",   n_wr - w0, 3);
        check("norm_wrhold_addr", wr_addr, 2);
        check("norm_wrhold_data", wr_data, 9'h100);

        // Empty image
        do_reset();
        w0 = n_wr;
        send(8'h00); send(8'h00);
        finish_image();
        check("empty_done", load_done, 1);
        check("empty_hold", cpu_hold, 0);
        drain_check("empty_pending");
        check("empty_nwr",  n_wr - w0, 0);

        // Backpressure: valid pattern 1,0,0,1,...
        do_reset();
        w0 = n_wr;
        send(8'h03); idle(2); send(8'h00); idle(2);
        exp_q.push_back({12'd0, 9'h1A5});
        send(8'hA5); idle(2); send(8'h01); idle(2);
        exp_q.push_back({12'd1, 9'h003});
        send(8'h03); idle(2); send(8'h00); idle(2);
        exp_q.push_back({12'd2, 9'h100});
        send(8'h00); idle(2); send(8'h01); idle(2);
        finish_image();
        check("bp_done", load_done, 1);
        check("bp_cnt",  word_cnt, 3);
        drain_check("bp_pending");
        check("bp_nwr",  n_wr - w0, 3);

        // Framing error on LEN_HI
        do_reset();
        w0 = n_wr;
        send(8'h05); send(8'h10);
        check("lenerr_err",   load_err, 1);
        check("lenerr_ready", rx_ready, 0);
        check("lenerr_hold",  cpu_hold, 1);
        check("lenerr_done",  load_done, 0);
        drain_check("lenerr_pending");
        check("lenerr_nwr",   n_wr - w0, 0);

        // Framing error on word HI byte
        do_reset();
        w0 = n_wr;
        send(8'h02); send(8'h00);
        send_word(8'h33, 8'h00, 12'd0);
        send_word(8'h44, 8'h02, 12'd1);
        check("hierr_err",  load_err, 1);
        check("hierr_hold", cpu_hold, 1);
        check("hierr_cnt",  word_cnt, 1);
        drain_check("hierr_pending");
        check("hierr_nwr",  n_wr - w0, 1);

        // Reset mid-load after first write
        do_reset();
        send(8'h03); send(8'h00);
        send_word(8'hA5, 8'h01, 12'd0);
        drain_check("mid_pending0");
        check("mid_cnt_pre", word_cnt, 1);
        do_reset();
        check("mid_rst_hold", cpu_hold, 1);
        check("mid_rst_cnt",  word_cnt, 0);
        check("mid_rst_wren", wr_en, 0);
        send(8'h02); send(8'h00);
        send_word(8'h11, 8'h00, 12'd0);
        send_word(8'h22, 8'h01, 12'd1);
        finish_image();
        check("mid_done", load_done, 1);
        check("mid_cnt",  word_cnt, 2);
        drain_check("mid_pending");

`ifdef LOADER_CHECKSUM_EN
        // Checksum mismatch: word still written, then error
        do_reset();
        send(8'h01); send(8'h00);
        send_word(8'h05, 8'h01, 12'd0);
        check("chk_xor_model", tb_xor, 8'h05);
        send(8'h04);
        check("chkbad_err",  load_err, 1);
        check("chkbad_hold", cpu_hold, 1);
        check("chkbad_done", load_done, 0);
        drain_check("chkbad_pending");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
